// File: rtl/por_sequencer.sv
// Power-on-reset recovery sequencer for two redundant flight data units.
// Debounces unit health, pulses POR to one non-prime unit at a time, retries, and locks out.
module por_sequencer #(
  parameter int unsigned HOLDOFF   = 50000,
  parameter int unsigned POR_WIDTH = 500000,
  parameter int unsigned BOOT_WAIT = 250000000,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned CNT_W     = 28
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] health,
  input  logic [1:0] prime,
  input  logic [1:0] clear_lockout,
  output logic [1:0] por,
  output logic [1:0] lockout,
  output logic       busy,
  output logic       sel,
  output logic       fault,
  output logic [7:0] retries
);

  typedef enum logic [1:0] {StIdle, StHold, StAssert, StBoot} state_e;

  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLDOFF - 1);
  localparam logic [CNT_W-1:0] PorLast  = CNT_W'(POR_WIDTH - 1);
  localparam logic [CNT_W-1:0] BootLast = CNT_W'(BOOT_WAIT - 1);
  localparam logic [3:0]       MaxRetry = 4'(MAX_RETRY);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             sel_q, sel_d;
  logic             last_q, last_d;
  logic             fault_q, fault_d;
  logic [1:0]       por_q, por_d;
  logic [1:0]       lockout_q, lockout_d;
  logic [1:0][3:0]  retry_q, retry_d;
  logic [1:0]       cand;
  logic [3:0]       bumped;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    sel_d     = sel_q;
    last_d    = last_q;
    fault_d   = 1'b0;
    por_d     = 2'b00;
    lockout_d = lockout_q;
    retry_d   = retry_q;
    cand      = ~health & ~lockout_q & ~prime;
    bumped    = (retry_q[sel_q] == 4'hf) ? 4'hf : retry_q[sel_q] + 4'd1;

    // Clear is applied first so a coincident lockout set below wins.
    for (int i = 0; i < 2; i++) begin
      if (clear_lockout[i]) begin
        lockout_d[i] = 1'b0;
        retry_d[i]   = 4'd0;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (|cand) begin
          state_d = StHold;
          timer_d = '0;
          sel_d   = (&cand) ? ~last_q : cand[1];
        end
      end
      StHold: begin
        if (health[sel_q] || prime[sel_q]) begin
          state_d = StIdle;
        end else if (timer_q == HoldLast) begin
          state_d     = StAssert;
          timer_d     = '0;
          por_d[sel_q] = 1'b1;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      StAssert: begin
        if (timer_q == PorLast) begin
          state_d = StBoot;
          timer_d = '0;
        end else begin
          timer_d      = timer_q + CNT_W'(1);
          por_d[sel_q] = 1'b1;
        end
      end
      StBoot: begin
        if (health[sel_q]) begin
          retry_d[sel_q] = 4'd0;
          last_d         = sel_q;
          state_d        = StIdle;
        end else if (timer_q == BootLast) begin
          retry_d[sel_q] = bumped;
          last_d         = sel_q;
          state_d        = StIdle;
          if (bumped == MaxRetry) begin
            lockout_d[sel_q] = 1'b1;
            fault_d          = 1'b1;
          end
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      sel_q     <= 1'b0;
      last_q    <= 1'b1;
      fault_q   <= 1'b0;
      por_q     <= 2'b00;
      lockout_q <= 2'b00;
      retry_q   <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      fault_q   <= fault_d;
      por_q     <= por_d;
      lockout_q <= lockout_d;
      retry_q   <= retry_d;
    end
  end

  assign por     = por_q;
  assign lockout = lockout_q;
  assign busy    = (state_q != StIdle);
  assign sel     = sel_q;
  assign fault   = fault_q;
  assign retries = retry_q;

endmodule

// File: tb/tb_por_sequencer.sv
// Bench for por_sequencer: a timeline model (service start stamp plus elapsed-cycle windows)
// checked every cycle, plus directed literal checks that pin the model to the expected timing.
module tb_por_sequencer;

  localparam int unsigned HOLDOFF   = 4;
  localparam int unsigned POR_WIDTH = 3;
  localparam int unsigned BOOT_WAIT = 10;
  localparam int unsigned MAX_RETRY = 2;
  localparam int unsigned CNT_W     = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] health = 2'b11;
  logic [1:0] prime = 2'b10;
  logic [1:0] clear_lockout = 2'b00;
  logic [1:0] por;
  logic [1:0] lockout;
  logic       busy;
  logic       sel;
  logic       fault;
  logic [7:0] retries;

  int n_pass  = 0;
  int n_total = 0;

  por_sequencer #(
    .HOLDOFF  (HOLDOFF),
    .POR_WIDTH(POR_WIDTH),
    .BOOT_WAIT(BOOT_WAIT),
    .MAX_RETRY(MAX_RETRY),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .health       (health),
    .prime        (prime),
    .clear_lockout(clear_lockout),
    .por          (por),
    .lockout      (lockout),
    .busy         (busy),
    .sel          (sel),
    .fault        (fault),
    .retries      (retries)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at time %0t", name, act, exp, $time);
  endtask

  // Model: a service is a start stamp t0; the phase is just the elapsed edge count since t0.
  int         m_cyc = 0;
  int         m_t0 = 0;
  logic       m_busy = 1'b0;
  logic       m_sel = 1'b0;
  logic       m_last = 1'b1;
  logic       m_fault = 1'b0;
  logic [1:0] m_lock = 2'b00;
  int         m_ret [2] = '{0, 0};

  always @(posedge clk or posedge reset) begin : model
    int         c, p, nt0;
    logic       nb, ns, nl, nf;
    logic [1:0] nlock, cand;
    int         nret [2];
    if (reset) begin
      m_cyc   <= 0;
      m_t0    <= 0;
      m_busy  <= 1'b0;
      m_sel   <= 1'b0;
      m_last  <= 1'b1;
      m_fault <= 1'b0;
      m_lock  <= 2'b00;
      m_ret   <= '{0, 0};
    end else begin
      c = m_cyc + 1;
      p = m_cyc - m_t0;
      nb = m_busy; ns = m_sel; nl = m_last; nf = 1'b0; nt0 = m_t0;
      nlock = m_lock; nret = m_ret;
      for (int i = 0; i < 2; i++) if (clear_lockout[i]) begin nlock[i] = 1'b0; nret[i] = 0; end
      if (!m_busy) begin
        cand = ~health & ~m_lock & ~prime;
        if (cand != 2'b00) begin
          nb = 1'b1;
          nt0 = c;
          ns = (cand == 2'b11) ? ~m_last : (cand == 2'b10);
        end
      end else if (p < int'(HOLDOFF)) begin
        if (health[m_sel] || prime[m_sel]) nb = 1'b0;
      end else if (p >= int'(HOLDOFF + POR_WIDTH)) begin
        if (health[m_sel]) begin
          nb = 1'b0; nl = m_sel; nret[m_sel] = 0;
        end else if (p == int'(HOLDOFF + POR_WIDTH + BOOT_WAIT) - 1) begin
          nb = 1'b0; nl = m_sel;
          nret[m_sel] = (m_ret[m_sel] >= 15) ? 15 : m_ret[m_sel] + 1;
          if (nret[m_sel] == int'(MAX_RETRY)) begin nlock[m_sel] = 1'b1; nf = 1'b1; end
        end
      end
      m_cyc   <= c;
      m_t0    <= nt0;
      m_busy  <= nb;
      m_sel   <= ns;
      m_last  <= nl;
      m_fault <= nf;
      m_lock  <= nlock;
      m_ret   <= nret;
    end
  end

  always @(negedge clk) begin : compare
    int         q;
    logic [1:0] e_por;
    q = m_cyc - m_t0;
    e_por = 2'b00;
    if (m_busy && q >= int'(HOLDOFF) && q < int'(HOLDOFF + POR_WIDTH)) e_por[m_sel] = 1'b1;
    check("m_por", {6'd0, por}, {6'd0, e_por});
    check("m_busy", {7'd0, busy}, {7'd0, m_busy});
    if (m_busy) check("m_sel", {7'd0, sel}, {7'd0, m_sel});
    check("m_lockout", {6'd0, lockout}, {6'd0, m_lock});
    check("m_fault", {7'd0, fault}, {7'd0, m_fault});
    check("m_retries", retries, {4'(m_ret[1]), 4'(m_ret[0])});
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #1 reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(3);
    check("reset_busy", {7'd0, busy}, 8'd0);
    check("reset_por", {6'd0, por}, 8'd0);

    // Basic restart of unit 0 with recovery in BOOT.
    health = 2'b10; prime = 2'b10;
    tick(4);  check("t1_por_e4", {6'd0, por}, 8'd0); check("t1_busy_e4", {7'd0, busy}, 8'd1);
    tick(1);  check("t1_por_e5", {6'd0, por}, 8'd1);
    tick(2);  check("t1_por_e7", {6'd0, por}, 8'd1);
    tick(1);  check("t1_por_e8", {6'd0, por}, 8'd0); check("t1_busy_e8", {7'd0, busy}, 8'd1);
    tick(2);  health = 2'b11; check("t1_busy_e10", {7'd0, busy}, 8'd1);
    tick(1);  check("t1_busy_e11", {7'd0, busy}, 8'd0); check("t1_ret", retries, 8'h00);
    tick(3);

    // Glitch shorter than the holdoff aborts.
    health = 2'b10;
    tick(2);  check("t2_busy", {7'd0, busy}, 8'd1); health = 2'b11;
    tick(4);  check("t2_idle", {7'd0, busy}, 8'd0); check("t2_ret", retries, 8'h00);

    // Prime unit is never reset.
    prime = 2'b01; health = 2'b10;
    tick(20); check("t3_noreset", {7'd0, busy}, 8'd0);
    prime = 2'b10;
    tick(5);  check("t3_por", {6'd0, por}, 8'd1);
    tick(3);  health = 2'b11;
    tick(2);  check("t3_idle", {7'd0, busy}, 8'd0);

    // Both unhealthy from reset: unit 0 first, then unit 1.
    reset = 1'b1; health = 2'b00; prime = 2'b00;
    tick(2);  reset = 1'b0;
    tick(1);  check("t4_sel0", {7'd0, sel}, 8'd0); check("t4_busy", {7'd0, busy}, 8'd1);
    tick(4);  check("t4_por0", {6'd0, por}, 8'd1);
    tick(3);  health = 2'b01;
    tick(1);  check("t4_idle", {7'd0, busy}, 8'd0);
    tick(1);  check("t4_sel1", {7'd0, sel}, 8'd1);
    tick(4);  check("t4_por1", {6'd0, por}, 8'd2);
    tick(3);  health = 2'b11;
    tick(2);  check("t4_done", {7'd0, busy}, 8'd0);

    // Unit 1 never recovers: two attempts, then lockout.
    prime = 2'b01; health = 2'b01;
    tick(18); check("t5_ret1", retries, 8'h10); check("t5_idle1", {7'd0, busy}, 8'd0);
    tick(18); check("t5_lock", {6'd0, lockout}, 8'd2); check("t5_fault", {7'd0, fault}, 8'd1);
    check("t5_ret2", retries, 8'h20);
    tick(1);  check("t5_fault_off", {7'd0, fault}, 8'd0);
    tick(30); check("t5_no_third", {7'd0, busy}, 8'd0);
    clear_lockout = 2'b10;
    tick(1);  clear_lockout = 2'b00;
    check("t5_clr_lock", {6'd0, lockout}, 8'd0); check("t5_clr_ret", retries, 8'h00);
    tick(1);  check("t5_resume", {7'd0, busy}, 8'd1); check("t5_resume_sel", {7'd0, sel}, 8'd1);
    tick(4);  check("t5_por", {6'd0, por}, 8'd2);

    // Asynchronous reset in the middle of a POR pulse.
    reset = 1'b1;
    #1;
    check("t6_por", {6'd0, por}, 8'd0); check("t6_busy", {7'd0, busy}, 8'd0);
    check("t6_ret", retries, 8'h00); check("t6_lock", {6'd0, lockout}, 8'd0);
    tick(2);  reset = 1'b0;
    tick(1);  check("t6_hold", {7'd0, busy}, 8'd1); check("t6_sel", {7'd0, sel}, 8'd1);
    tick(4);  check("t6_por_again", {6'd0, por}, 8'd2);
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/por_sequencer.md
# por_sequencer

Recovery controller for the two redundant flight data units supervised by the fault detection unit. It watches per-unit health and the current prime selection. When a non-prime unit stays unhealthy past a debounce window, it issues a power-on-reset pulse to that unit and waits for it to come back. Only one unit is restarted at a time, failed restarts are retried, and a unit is locked out after repeated failures. Sits beside the FDU and drives its `por[1:0]` lines.

## Interface
- `HOLDOFF`, 50000: cycles a unit must stay unhealthy before a restart is issued (≥1)
- `POR_WIDTH`, 500000: cycles `por[i]` is held high per restart (≥1)
- `BOOT_WAIT`, 250000000: cycles allowed after POR release for health to return (≥1)
- `MAX_RETRY`, 3: consecutive failed restarts before lockout (1..15)
- `CNT_W`, 28: shared timer width; must hold max(HOLDOFF, POR_WIDTH, BOOT_WAIT)
- `clk` in 1: system clock
- `reset` in 1: asynchronous, active-high
- `health` in 2: per-unit watchdog health, 1 = healthy
- `prime` in 2: current prime one-hot from FDU (00 = none)
- `clear_lockout` in 2: per-unit lockout/retry clear, level sampled each cycle
- `por` out 2: registered POR pulse to unit 0/1
- `lockout` out 2: unit permanently excluded from restarts
- `busy` out 1: sequencer not in IDLE
- `sel` out 1: unit currently being serviced (valid while busy)
- `fault` out 1: one-cycle pulse when a lockout is set
- `retries` out 8: [3:0] unit 0, [7:4] unit 1 consecutive failure counts

## Operation
- Candidate i: `health[i]==0 && lockout[i]==0 && prime[i]==0`. The prime unit is never reset.
- Arbitration: round robin via `last` pointer (reset 1, so unit 0 wins first tie). When both units are candidates, pick `~last`. Otherwise pick the single candidate.
- States: IDLE, HOLD, ASSERT, BOOT.
- IDLE: if any candidate, latch `sel`, clear timer → HOLD.
- HOLD: timer counts. If `health[sel]` rises or `prime[sel]` asserts → IDLE (abort, no retry change). When the timer reaches HOLDOFF-1 → ASSERT, clear timer.
- ASSERT: `por[sel]`=1. When the timer reaches POR_WIDTH-1 → BOOT, clear timer. `por` drops on entry to BOOT.
- BOOT: if `health[sel]`=1 → retries[sel]=0, `last`=sel, IDLE.
- BOOT timeout: when the timer reaches BOOT_WAIT-1 without health → retries[sel]+1, `last`=sel, IDLE. If the new count == MAX_RETRY, set `lockout[sel]` and pulse `fault`.
- ASSERT and BOOT ignore `prime` changes and the other unit's health.
- `clear_lockout[i]`: clears `lockout[i]` and retries[i] next edge. If it coincides with lockout being set for the same unit, the set wins.
- Retry counters saturate at 15 and never wrap.
- `por` bits are mutually exclusive.

## Timing
- Reset (async, immediate): state IDLE, `por`=00, `lockout`=00, `busy`=0, `sel`=0, `fault`=0, `retries`=0, timer 0, `last`=1.
- Candidate first seen at edge N (IDLE): HOLD at N+1.
- `por[sel]` high from edge N+1+HOLDOFF for exactly POR_WIDTH cycles.
- `busy` high from N+1 through the last BOOT cycle.
- Health seen at BOOT cycle k: IDLE at k+1. A new candidate can be taken at k+1, so the earliest next HOLD is k+2.
- Timeout: `fault` and `lockout` assert on the same edge as the return to IDLE.
- Reset mid-ASSERT: `por` drops asynchronously. No retry is recorded.

## Test plan
- HOLDOFF=4, POR_WIDTH=3, BOOT_WAIT=10: health=10, prime=10, unit 0 low at edge 0 → por=01 on edges 5–7, BOOT at 8. Health returns at 10 → IDLE at 11, retries[3:0]=0.
- Glitch abort: health[0] low for 2 cycles with HOLDOFF=4 → por stays 00, retries unchanged, IDLE after recovery.
- Prime protection: prime=01, health=10 → no pulse ever. Then prime→10 → unit 0 restarted after HOLDOFF.
- Both unhealthy, prime=00 from reset → unit 0 pulsed first. After its BOOT completes, unit 1 is pulsed. por never 11.
- MAX_RETRY=2, unit 1 never recovers → two pulses, retries[7:4]=2, lockout=10, one-cycle fault, no third pulse. clear_lockout=10 → lockout=00, restarts resume after HOLDOFF.
- Async reset asserted during ASSERT → por=00 within the same cycle, all outputs at reset values. After reset release, sequencing restarts from HOLD.
